// File: rtl/comparator_nbit_serial.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake.
// Define CMP_SIGNED_EN to compare operands as two's complement.
module comparator_nbit_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             GT,
  output logic             EQ,
  output logic             LT
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] MsbIdx = IW'(WIDTH - 1);

`ifdef CMP_SIGNED_EN
  localparam logic SgnEn = 1'b1;
`else
  localparam logic SgnEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE_S  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;

  logic a_bit;
  logic b_bit;
  logic inv;

  // Operands shift left so the bit under test is always the top bit.
  assign a_bit = a_q[WIDTH-1];
  assign b_bit = b_q[WIDTH-1];
  assign inv   = SgnEn & (idx_q == MsbIdx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            idx_q   <= MsbIdx;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          if (a_bit != b_bit) begin
            gt_q    <= inv ? b_bit : a_bit;
            lt_q    <= inv ? a_bit : b_bit;
            done_q  <= 1'b1;
            state_q <= DONE_S;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE_S;
          end else begin
            idx_q <= idx_q - IW'(1);
            a_q   <= a_q << 1;
            b_q   <= b_q << 1;
          end
        end
        DONE_S: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign GT   = gt_q;
  assign EQ   = eq_q;
  assign LT   = lt_q;

endmodule

// File: tb/tb_comparator_nbit_serial.sv
// Scoreboard bench for comparator_nbit_serial at WIDTH=8 and WIDTH=1.
// Expected results come from an arithmetic reference model.
module tb_comparator_nbit_serial;

`ifdef CMP_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] A8 = '0;
  logic [7:0] B8 = '0;
  logic       busy8, done8, GT8, EQ8, LT8;

  logic       start1 = 1'b0;
  logic [0:0] A1 = '0;
  logic [0:0] B1 = '0;
  logic       busy1, done1, GT1, EQ1, LT1;

  comparator_nbit_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .GT(GT8), .EQ(EQ8), .LT(LT8)
  );

  comparator_nbit_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1),
    .busy(busy1), .done(done1), .GT(GT1), .EQ(EQ1), .LT(LT1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] r;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int         checks = 0;
  int         errors = 0;
  int         phase = 0;
  logic [2:0] hold_exp = '0;
  int         tmo_cnt = 0;
  int         tmo_seen = 0;
  bit         drain_req = 1'b0;
  bit         drain_did = 1'b0;

  // Result {GT,EQ,LT} from integer comparison; latency from the
  // highest bit position at which the operands differ.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input int w);
    exp_t   e;
    longint va;
    longint vb;
    longint x;
    int     p;
    va = longint'(a);
    vb = longint'(b);
    if (SGN) begin
      if (a[w-1]) va = va - (longint'(1) << w);
      if (b[w-1]) vb = vb - (longint'(1) << w);
    end
    e.r = {va > vb, va == vb, va < vb};
    x = longint'(a ^ b);
    p = -1;
    for (int i = 0; i < w; i++) if (x[i]) p = i;
    e.lat = (p < 0) ? w + 1 : w - p + 1;
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (tmo_cnt != tmo_seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: DUT stayed busy, got busy want idle at cycle %0d", cyc);
      tmo_seen = tmo_cnt;
    end
    if (!rst) begin
      if (done8) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w8_unexpected_done: got done=1 want 0 at cycle %0d", cyc);
        end else begin
          e = q8.pop_front();
          chk("w8_result", {GT8, EQ8, LT8}, e.r);
          chk("w8_latency", cyc - e.acc + 1, e.lat);
        end
      end else if (busy8) begin
        chk("w8_cleared_in_compare", {GT8, EQ8, LT8}, 0);
      end
      if (done1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w1_unexpected_done: got done=1 want 0 at cycle %0d", cyc);
        end else begin
          e = q1.pop_front();
          chk("w1_result", {GT1, EQ1, LT1}, e.r);
          chk("w1_latency", cyc - e.acc + 1, e.lat);
        end
      end else if (busy1) begin
        chk("w1_cleared_in_compare", {GT1, EQ1, LT1}, 0);
      end
      case (phase)
        1: begin
          chk("w8_reset_idle", {busy8, done8, GT8, EQ8, LT8}, 0);
          chk("w1_reset_idle", {busy1, done1, GT1, EQ1, LT1}, 0);
        end
        2: begin
          chk("w8_hold_result", {GT8, EQ8, LT8}, hold_exp);
          chk("w8_hold_idle", {busy8, done8}, 0);
        end
        3: chk("w8_mid_reset", {busy8, done8, GT8, EQ8, LT8}, 0);
        default: ;
      endcase
    end
    if (drain_req && !drain_did) begin
      chk("w8_drain", q8.size(), 0);
      chk("w1_drain", q1.size(), 0);
      drain_did = 1'b1;
    end
  end

  // All stimulus tasks are entered and left 1 time unit after a posedge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input int gap, input bit push);
    exp_t e;
    int   n;
    n = 0;
    while (busy8 && n < 300) begin
      A8 = 8'($urandom);
      B8 = 8'($urandom);
      start8 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) tmo_cnt++;
    start8 = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    A8 = a;
    B8 = b;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    if (push) begin
      e = model(64'(a), 64'(b), 8);
      e.acc = cyc;
      q8.push_back(e);
    end
    A8 = 8'($urandom);
    B8 = 8'($urandom);
  endtask

  task automatic issue1(input logic a, input logic b, input int gap);
    exp_t e;
    int   n;
    n = 0;
    while (busy1 && n < 300) begin
      A1 = 1'($urandom);
      B1 = 1'($urandom);
      start1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) tmo_cnt++;
    start1 = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    A1 = a;
    B1 = b;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    e = model(64'(a), 64'(b), 1);
    e.acc = cyc;
    q1.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy8 || busy1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) tmo_cnt++;
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int         m;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    phase = 1;
    repeat (5) begin @(posedge clk); #1; end
    phase = 0;

    issue8(8'hA5, 8'hA5, 0, 1'b1);
    wait_idle();
    hold_exp = 3'b010;
    phase = 2;
    repeat (3) begin @(posedge clk); #1; end
    phase = 0;

    issue8(8'h80, 8'h7F, 0, 1'b1);
    wait_idle();
    hold_exp = SGN ? 3'b001 : 3'b100;
    phase = 2;
    repeat (2) begin @(posedge clk); #1; end
    phase = 0;

    issue8(8'h12, 8'h13, 0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    A8 = 8'hFF;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_idle();

    issue8(8'h40, 8'h00, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    phase = 3;
    repeat (4) begin @(posedge clk); #1; end
    phase = 0;
    issue8(8'h40, 8'h00, 0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom);
      m = $urandom_range(0, 3);
      if (m == 0) b = a;
      else if (m == 1) b = a ^ (8'd1 << $urandom_range(0, 7));
      else b = 8'($urandom);
      issue8(a, b, $urandom_range(0, 2), 1'b1);
    end
    wait_idle();

    issue1(1'b0, 1'b0, 0);
    issue1(1'b0, 1'b1, 0);
    issue1(1'b1, 1'b0, 0);
    issue1(1'b1, 1'b1, 0);
    for (int i = 0; i < 20; i++)
      issue1(1'($urandom), 1'($urandom), $urandom_range(0, 1));
    wait_idle();

    repeat (2) begin @(posedge clk); #1; end
    drain_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
